// File: rtl/rob_sched_pkg.sv
// Shared ROB geometry and completion-port constants for the ROB scheduler.
package rob_sched_pkg;
    localparam int ROB_NUM = 64;
    localparam int ROB_SEL = 6;
    localparam int NUM_FU  = 4;
    localparam int FU_SEL  = $clog2(NUM_FU);

    localparam logic [ROB_SEL:0] ROB_FULL = (ROB_SEL + 1)'(ROB_NUM);

    typedef logic [ROB_SEL-1:0] rob_addr_t;
endpackage

// File: rtl/rob_sched_rr_arbiter.sv
// N-way round-robin arbiter (N a power of two); the search starts at r_ptr and
// the pointer moves just past the winner whenever a grant is enabled.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt,
    output logic         o_hit,
    output logic [W-1:0] o_idx
);
    logic [W-1:0] r_ptr;
    logic [N-1:0] w_rot;
    logic [N-1:0] w_first;
    logic [N-1:0] w_gnt_raw;
    logic [W-1:0] w_off;

    // Rotate so the pointer position is bit 0, isolate the lowest set bit, rotate back.
    assign w_rot     = N'({i_req, i_req} >> r_ptr);
    assign w_first   = w_rot & (~w_rot + N'(1));
    assign w_gnt_raw = N'(({w_first, w_first} << r_ptr) >> N);

    always_comb begin
        w_off = '0;
        for (int k = 0; k < N; k++) begin
            if (w_first[k]) begin
                w_off = W'(k);
            end
        end
    end

    assign o_hit = (|i_req) & i_en;
    assign o_idx = r_ptr + w_off;
    assign o_gnt = w_gnt_raw & {N{i_en}};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (o_hit) begin
            r_ptr <= o_idx + W'(1);
        end
    end
endmodule

// File: rtl/rob_sched.sv
// ROB scheduler: allocation tail pointer, occupancy count and full/empty flags,
// plus round-robin arbitration of FU completions onto the single finish port.
module rob_sched
    import rob_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dp_req_i,
    output logic                      dp_grant_o,
    output logic [ROB_SEL-1:0]        dp_addr_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [ROB_SEL:0]          count_o,
    input  logic                      commit_i,
    input  logic                      flush_i,
    input  logic [NUM_FU-1:0]         fu_req_i,
    input  logic [NUM_FU*ROB_SEL-1:0] fu_addr_i,
    output logic [NUM_FU-1:0]         fu_gnt_o,
    output logic                      finish_o,
    output logic [ROB_SEL-1:0]        finish_addr_o
);
    rob_addr_t          r_head;
    rob_addr_t          r_tail;
    logic [ROB_SEL:0]   r_count;
    logic               r_finish;
    rob_addr_t          r_finish_addr;

    logic               w_commit;
    logic               w_arb_en;
    logic               w_arb_hit;
    logic [FU_SEL-1:0]  w_arb_idx;
    rob_addr_t          w_fu_addr [NUM_FU];

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu_addr
            assign w_fu_addr[gi] = fu_addr_i[gi*ROB_SEL +: ROB_SEL];
        end
    endgenerate

    assign full_o        = (r_count == ROB_FULL);
    assign empty_o       = (r_count == '0);
    assign count_o       = r_count;
    assign dp_addr_o     = r_tail;
    assign finish_o      = r_finish;
    assign finish_addr_o = r_finish_addr;

    // A commit against an empty ROB is a protocol error and is dropped here.
    assign w_commit   = commit_i & ~empty_o;
    assign w_arb_en   = reset & ~flush_i;
    assign dp_grant_o = reset & dp_req_i & ~full_o & ~flush_i;

    rr_arbiter #(
        .N (NUM_FU),
        .W (FU_SEL)
    ) u_arb (
        .clk     (clk),
        .i_rst_n (reset),
        .i_req   (fu_req_i),
        .i_en    (w_arb_en),
        .o_gnt   (fu_gnt_o),
        .o_hit   (w_arb_hit),
        .o_idx   (w_arb_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head <= r_head + ROB_SEL'(w_commit);
            if (flush_i) begin
                r_tail  <= r_head + ROB_SEL'(w_commit);
                r_count <= '0;
            end else begin
                if (dp_grant_o) begin
                    r_tail <= r_tail + ROB_SEL'(1);
                end
                if (dp_grant_o && !w_commit) begin
                    r_count <= r_count + (ROB_SEL + 1)'(1);
                end else if (!dp_grant_o && w_commit) begin
                    r_count <= r_count - (ROB_SEL + 1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_finish      <= 1'b0;
            r_finish_addr <= '0;
        end else begin
            r_finish <= w_arb_hit;
            if (w_arb_hit) begin
                r_finish_addr <= w_fu_addr[w_arb_idx];
            end
        end
    end
endmodule

// File: tb/tb_rob_sched.sv
// Self-checking bench for rob_sched: cycle-level reference model plus a
// completion scoreboard queue filled on grant and drained when finish_o rises.
module tb_rob_sched;
    import rob_sched_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      dp_req_i = 1'b0;
    logic                      dp_grant_o;
    logic [ROB_SEL-1:0]        dp_addr_o;
    logic                      full_o;
    logic                      empty_o;
    logic [ROB_SEL:0]          count_o;
    logic                      commit_i = 1'b0;
    logic                      flush_i = 1'b0;
    logic [NUM_FU-1:0]         fu_req_i = '0;
    logic [NUM_FU*ROB_SEL-1:0] fu_addr_i = '0;
    logic [NUM_FU-1:0]         fu_gnt_o;
    logic                      finish_o;
    logic [ROB_SEL-1:0]        finish_addr_o;

    rob_sched dut (
        .clk           (clk),
        .reset         (reset),
        .dp_req_i      (dp_req_i),
        .dp_grant_o    (dp_grant_o),
        .dp_addr_o     (dp_addr_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .count_o       (count_o),
        .commit_i      (commit_i),
        .flush_i       (flush_i),
        .fu_req_i      (fu_req_i),
        .fu_addr_i     (fu_addr_i),
        .fu_gnt_o      (fu_gnt_o),
        .finish_o      (finish_o),
        .finish_addr_o (finish_addr_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int illegal_hits = 0;

    int m_head = 0;
    int m_tail = 0;
    int m_count = 0;
    int m_rr = 0;
    int fin_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model.
    task automatic cyc(input logic dp, input logic cm, input logic fl, input logic [NUM_FU-1:0] fr);
        int dpg;
        int win;
        int idx;
        int cok;
        int a;
        logic [NUM_FU-1:0] eg;
        dp_req_i = dp;
        commit_i = cm;
        flush_i  = fl;
        fu_req_i = fr;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_addr_i[i*ROB_SEL +: ROB_SEL] = ROB_SEL'($urandom);
        end
        @(negedge clk);
        dpg = (dp && m_count != ROB_NUM && !fl) ? 1 : 0;
        check_eq("dp_grant", 32'(dp_grant_o), 32'(dpg));
        check_eq("dp_addr", 32'(dp_addr_o), 32'(m_tail));
        check_eq("count", 32'(count_o), 32'(m_count));
        check_eq("full", 32'(full_o), 32'(m_count == ROB_NUM));
        check_eq("empty", 32'(empty_o), 32'(m_count == 0));
        win = -1;
        if (!fl) begin
            for (int k = 0; k < NUM_FU; k++) begin
                idx = (m_rr + k) % NUM_FU;
                if (win < 0 && fr[idx]) win = idx;
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        check_eq("fu_gnt", 32'(fu_gnt_o), 32'(eg));
        if (fin_q.size() > 0) begin
            a = fin_q.pop_front();
            check_eq("finish_valid", 32'(finish_o), 32'd1);
            check_eq("finish_addr", 32'(finish_addr_o), 32'(a));
            $display("completion: addr=%0d expected=%0d", finish_addr_o, a);
        end else begin
            check_eq("finish_idle", 32'(finish_o), 32'd0);
        end
        if (cm && empty_o) illegal_hits++;
        if (dpg != 0) $display("alloc: addr=%0d count_before=%0d", dp_addr_o, m_count);
        cok = (cm && m_count != 0) ? 1 : 0;
        if (win >= 0) begin
            fin_q.push_back(int'(fu_addr_i[win*ROB_SEL +: ROB_SEL]));
            m_rr = (win + 1) % NUM_FU;
        end
        m_head = (m_head + cok) % ROB_NUM;
        if (fl) begin
            m_tail  = m_head;
            m_count = 0;
        end else begin
            m_tail  = (m_tail + dpg) % ROB_NUM;
            m_count = m_count + dpg - cok;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges, with whatever stimulus is currently applied.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_dp_addr", 32'(dp_addr_o), 32'd0);
        check_eq("rst_count", 32'(count_o), 32'd0);
        check_eq("rst_empty", 32'(empty_o), 32'd1);
        check_eq("rst_full", 32'(full_o), 32'd0);
        check_eq("rst_finish", 32'(finish_o), 32'd0);
        check_eq("rst_finish_addr", 32'(finish_addr_o), 32'd0);
        check_eq("rst_dp_grant", 32'(dp_grant_o), 32'd0);
        check_eq("rst_fu_gnt", 32'(fu_gnt_o), 32'd0);
        m_head = 0; m_tail = 0; m_count = 0; m_rr = 0;
        fin_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();
        cyc(1, 0, 0, '0);
        check_eq("first_alloc_addr_next", 32'(dp_addr_o), 32'd1);

        // Mid-traffic reset
        for (int i = 0; i < 10; i++) cyc(1, (i > 2), 0, 4'(i + 3));
        dp_req_i = 1'b1;
        fu_req_i = 4'b1111;
        do_reset();

        // Fill to full, overflow request, commit+request same cycle
        for (int i = 0; i < ROB_NUM; i++) cyc(1, 0, 0, '0);
        check_eq("fill_full", 32'(full_o), 32'd1);
        check_eq("fill_count", 32'(count_o), 32'(ROB_NUM));
        cyc(1, 0, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(1, 0, 0, '0);
        cyc(0, 0, 0, '0);

        // Wrap: bring head = tail = 62, then allocate 4 and commit 4
        do_reset();
        for (int i = 0; i < 62; i++) cyc(1, (i > 0), 0, '0);
        cyc(0, 1, 0, '0);
        check_eq("wrap_start_tail", 32'(dp_addr_o), 32'd62);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0);
        check_eq("wrap_empty", 32'(empty_o), 32'd1);

        // Arbitration: all FUs requesting from a fresh pointer
        do_reset();
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 4'b1111);
        cyc(0, 0, 0, '0);

        // Flush with count=10, head=5, plus commit/dispatch/FU requests
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1, (i >= 1 && i <= 5), 0, '0);
        cyc(1, 1, 1, 4'b1111);
        check_eq("flush_count", 32'(count_o), 32'd0);
        check_eq("flush_tail", 32'(dp_addr_o), 32'd6);
        check_eq("flush_finish", 32'(finish_o), 32'd0);

        // Illegal commit on empty ROB
        cyc(0, 1, 0, '0);
        cyc(0, 0, 0, '0);
        check_eq("illegal_commit_seen", 32'(illegal_hits), 32'd1);

        // Random traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cyc(1'($urandom_range(0, 1)),
                (m_count > 0) && ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 39) == 0),
                4'($urandom));
        end
        cyc(0, 0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rob_sched.md
# rob_sched

ROB scheduler. Owns the ROB allocation (tail) pointer and occupancy count, and tells dispatch when the ROB is full. It also arbitrates between the execution units' completion reports for the ROB's single finish-write port. It sits between dispatch, the functional units and the ROB, and drives the ROB's `dp1_*` address and `finish_ex_alu1_*` inputs.

## Interface
- `ROB_NUM`, 64: ROB entries; must be a power of two.
- `ROB_SEL`, 6: log2(`ROB_NUM`).
- `NUM_FU`, 4: completion requesters.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `dp_req_i`  in  1: dispatch requests one ROB entry this cycle.
- `dp_grant_o`  out  1: entry allocated this cycle; drives ROB `dp1_i`.
- `dp_addr_o`  out  `ROB_SEL`: allocated entry (tail pointer); drives ROB `dp1_addr_i`.
- `full_o`  out  1: count == `ROB_NUM`.
- `empty_o`  out  1: count == 0.
- `count_o`  out  `ROB_SEL`+1: occupied entries.
- `commit_i`  in  1: ROB retired its head entry this cycle.
- `flush_i`  in  1: discard all un-committed entries.
- `fu_req_i`  in  `NUM_FU`: FU *i* has a completion to report.
- `fu_addr_i`  in  `NUM_FU`*`ROB_SEL`: ROB address of each report; FU *i* uses bits [i*`ROB_SEL` +: `ROB_SEL`].
- `fu_gnt_o`  out  `NUM_FU`: one-hot grant; the FU drops or advances its request the next cycle.
- `finish_o`  out  1: registered completion valid; drives ROB `finish_ex_alu1_i`.
- `finish_addr_o`  out  `ROB_SEL`: registered completion address.

## Operation
- **State:** `head` and `tail` (`ROB_SEL` bits each, wrap modulo `ROB_NUM`), `count` (`ROB_SEL`+1 bits), `rr_ptr` (round-robin priority index), and the `finish_o`/`finish_addr_o` registers.
- **Allocation**
  - `dp_grant_o` = `dp_req_i` & !`full_o` & !`flush_i`; combinational from registered `count`.
  - No bypass: a commit in the same cycle does not free a slot for a full ROB.
  - `dp_addr_o` = `tail`; on grant, `tail` <= `tail`+1.
- **Commit:** when `commit_i` is high, `head` <= `head`+1.
- **Count:** `count` <= `count` + `dp_grant_o` − `commit_i`.
  - `commit_i` while empty is a protocol error: it is ignored (head and count unchanged), and the bench asserts on it.
- **Flush** (has priority over everything else):
  - `tail` <= `head` + `commit_i`; `count` <= 0.
  - `fu_gnt_o` forced to 0; `finish_o` <= 0 next cycle.
  - `rr_ptr` is held.
- **Completion arbitration**
  - Round-robin over `fu_req_i`, starting the search at `rr_ptr` and wrapping.
  - At most one grant per cycle; a grant is issued whenever any request is present and `flush_i` is low.
  - On a grant to FU *i*: `rr_ptr` <= (*i*+1) mod `NUM_FU`; `finish_o` <= 1; `finish_addr_o` <= that FU's address.
  - With no grant: `finish_o` <= 0.
- **Reset values:** `head` = `tail` = 0, `count` = 0, `rr_ptr` = 0, `finish_o` = 0, `finish_addr_o` = 0. As a result `dp_addr_o` = 0, `empty_o` = 1, `full_o` = 0, and all grants are 0.

## Timing
- Allocation grant: 0 cycles (combinational). The pointer advances at the same edge the ROB captures the entry.
- Completion: grant in cycle N; `finish_o` valid in cycle N+1 for exactly one cycle. Sustained throughput is one completion per cycle.
- Fairness: a continuously requesting FU is granted within `NUM_FU` cycles.
- `full_o`, `empty_o` and `count_o` reflect state after the last edge.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first grant can occur in the first cycle after release.

## Structure
- Shared package/consts: `ROB_NUM`, `ROB_SEL` (already the core's ROB constants) and `NUM_FU`.
- One sub-module, `rr_arbiter`: a parameterised `NUM_FU`-way round-robin arbiter with request, grant, and a pointer-update enable.
- The allocation pointer/count logic stays in the top level.

## Test plan
- **Reset:** assert `reset`=0 mid-traffic → all outputs match the reset values; after release, `dp_req_i`=1 → `dp_grant_o`=1, `dp_addr_o`=0.
- **Fill to full:** 64 consecutive `dp_req_i` with no commits → addresses 0..63, `full_o`=1, `count_o`=64.
  - A 65th request → `dp_grant_o`=0.
  - `commit_i` plus a request in the same cycle → no grant that cycle; a grant with addr 0 the next cycle.
- **Wrap:** at `head`=`tail`=62, allocate 4 → addresses 62, 63, 0, 1; commit 4 → `empty_o`=1.
- **Arbitration:** `fu_req_i`=4'b1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3. `finish_addr_o` lags each grant by one cycle with the matching `fu_addr_i`.
- **Flush:** `count`=10, `head`=5, then `flush_i` together with `commit_i`, `dp_req_i` and `fu_req_i` → no grants; next cycle `count_o`=0, `dp_addr_o`=6, `finish_o`=0.
- **Illegal commit:** `commit_i` while empty → state unchanged; assertion fires.
